seg_scan_driver: RTL

- Memory-mapped seven-segment display controller that consumes the CPU's display-register stores and drives the board's `seg[7:0]` / `del[2:0]` pins.
- Sits directly downstream of the CPU core's store path.
- Time-multiplexes eight hex digits with a programmable scan rate, per-digit blanking slot and tear-free frame update.
- Replaces the ad-hoc seg/del logic inside the CPU top.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_hex_decode.sv | 9 +
 rtl/seg_scan_driver.sv | 70 +++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
package seg_pkg;
    localparam int EN_BIT   = 0;
    localparam int MASK_LSB = 8;
    localparam int DP_LSB   = 16;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    // Active-low g..a patterns, indexed by nibble value 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble to active-low g..a segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit hex display with tear-free frame update.
// Defining SEG_LZ_BLANK_EN enables leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    output logic [7:0]  seg,
    output logic [2:0]  del,
    output logic        frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] div_cnt;
    logic [2:0]    digit;
    logic [31:0]   shadow, disp;
    logic          enable;
    logic [7:0]    mask, dp;
    logic [3:0]    nib;
    logic [6:0]    hex;
    logic          wrap, lz, blank;

    seg_hex_decode u_dec (.nib(nib), .seg(hex));

    always_comb begin
        nib  = disp[{digit, 2'b00} +: 4];
        wrap = div_cnt == CW'(SCAN_DIV - 1);
`ifdef SEG_LZ_BLANK_EN
        // Blank when every nibble from this digit upward is zero; digit 0 always shows.
        lz   = digit != 3'd0 && (disp >> {digit, 2'b00}) == 32'd0;
`else
        lz   = 1'b0;
`endif
        blank = !enable || !mask[digit] || 32'(div_cnt) < 32'(BLANK_CYC) || lz;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt    <= '0;
            digit      <= 3'd0;
            shadow     <= 32'd0;
            disp       <= 32'd0;
            enable     <= 1'b1;
            mask       <= 8'hFF;
            dp         <= 8'h00;
            seg        <= SEG_OFF;
            del        <= 3'd0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= wrap ? '0 : div_cnt + CW'(1);
            if (wrap) digit <= digit + 3'd1;
            if (wrap && digit == 3'd7) disp <= shadow;
            frame_tick <= wrap && digit == 3'd7;
            if (wr_en && !wr_sel) shadow <= wr_data;
            if (wr_en && wr_sel) begin
                enable <= wr_data[EN_BIT];
                mask   <= wr_data[MASK_LSB +: 8];
                dp     <= wr_data[DP_LSB +: 8];
            end
            del <= digit;
            seg <= blank ? SEG_OFF : {~dp[digit], hex};
        end
    end
endmodule
